// File: rtl/cmp_share_ctrl.sv
// Round-robin sequencer for the shared 2-bit-slice equality unit.
// It captures one requester's operands, walks them one slice per clock and reports eq/any-match.
module cmp_share_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0_in,
  input  logic [WIDTH-1:0] b0_in,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1_in,
  input  logic [WIDTH-1:0] b1_in,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             eq,
  output logic             any_match
);

  localparam int unsigned S    = WIDTH / 2;
  localparam int unsigned CntW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(S - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic             eq_w_q, eq_w_d;
  logic             any_w_q, any_w_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             eq_q, eq_d;
  logic             any_q, any_d;

  logic             grant0, grant1;
  logic [1:0]       slice_match;
  logic             slice_eq, slice_any;

  // Operands shift right each slice, so the active slice is always bits [1:0].
  assign slice_match = a_q[1:0] ~^ b_q[1:0];
  assign slice_eq    = &slice_match;
  assign slice_any   = |slice_match;

  // On contention the requester that was not served last wins.
  assign grant0 = req0 & (~req1 | last_id_q);
  assign grant1 = req1 & ~grant0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    eq_w_d    = eq_w_q;
    any_w_d   = any_w_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    eq_d      = eq_q;
    any_d     = any_q;

    case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          a_d       = grant1 ? a1_in : a0_in;
          b_d       = grant1 ? b1_in : b0_in;
          id_d      = grant1;
          last_id_d = grant1;
          cnt_d     = '0;
          eq_w_d    = 1'b1;
          any_w_d   = 1'b0;
          gnt0_d    = grant0;
          gnt1_d    = grant1;
          busy_d    = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        eq_w_d  = eq_w_q & slice_eq;
        any_w_d = any_w_q | slice_any;
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          eq_d      = eq_w_d;
          any_d     = any_w_d;
          done_id_d = id_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      eq_w_q    <= 1'b0;
      any_w_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      eq_q      <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      eq_w_q    <= eq_w_d;
      any_w_q   <= any_w_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      eq_q      <= eq_d;
      any_q     <= any_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign eq        = eq_q;
  assign any_match = any_q;

endmodule
